// File: rtl/control_fsm.sv
// Fetch/decode/execute sequencer for the processor core. It handles the memory ready
// handshake with a timeout, run/stop on start, a halt state and a sticky error state.
module control_fsm #(
    parameter int IR_WIDTH     = 16,
    parameter int OPCODE_WIDTH = 6,
    parameter int STATE_WIDTH  = 6,
    parameter int TIMEOUT      = 15
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   start,
    input  logic [IR_WIDTH-1:0]    IR,
    input  logic                   mem_ready,
    input  logic                   zero_flag,
    output logic [STATE_WIDTH-1:0] state,
    output logic                   mem_req,
    output logic                   mem_we,
    output logic                   ir_load,
    output logic                   pc_inc,
    output logic                   pc_load,
    output logic                   alu_en,
    output logic                   alu_op,
    output logic                   busy,
    output logic                   halted,
    output logic                   error
);

    typedef enum logic [3:0] {
        S_IDLE       = 4'd0,
        S_FETCH      = 4'd1,
        S_FETCH_WAIT = 4'd2,
        S_DECODE     = 4'd3,
        S_EXEC_ALU   = 4'd4,
        S_MEM_ADDR   = 4'd5,
        S_MEM_WAIT   = 4'd6,
        S_WRITEBACK  = 4'd7,
        S_JUMP       = 4'd8,
        S_HALT       = 4'd9,
        S_ERROR      = 4'd10
    } state_t;

    localparam logic [7:0] TMO_LAST = 8'(TIMEOUT - 1);

    state_t                  state_q, state_d;
    logic [7:0]              cnt_q, cnt_d;
    logic [OPCODE_WIDTH-1:0] op_q, op_d;
    logic [OPCODE_WIDTH-1:0] opcode;
    logic [31:0]             opc_ext, op_ext;
    state_t                  boundary;
    logic                    unused_ir;

    assign opcode    = IR[IR_WIDTH-1 -: OPCODE_WIDTH];
    assign opc_ext   = 32'(opcode);
    assign op_ext    = 32'(op_q);
    assign boundary  = start ? S_FETCH : S_IDLE;
    assign unused_ir = ^IR;
    assign state     = STATE_WIDTH'(state_q);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
            cnt_q   <= 8'd0;
            op_q    <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            op_q    <= op_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        op_d    = op_q;
        mem_req = 1'b0;
        mem_we  = 1'b0;
        ir_load = 1'b0;
        pc_inc  = 1'b0;
        pc_load = 1'b0;
        alu_en  = 1'b0;
        alu_op  = 1'b0;
        busy    = 1'b1;
        halted  = 1'b0;
        error   = 1'b0;
        case (state_q)
            S_IDLE: begin
                busy = 1'b0;
                if (start) state_d = S_FETCH;
            end
            S_FETCH: begin
                mem_req = 1'b1;
                cnt_d   = 8'd0;
                state_d = S_FETCH_WAIT;
            end
            S_FETCH_WAIT: begin
                mem_req = 1'b1;
                // A ready on the last allowed cycle still completes the fetch
                if (mem_ready) begin
                    ir_load = 1'b1;
                    pc_inc  = 1'b1;
                    state_d = S_DECODE;
                end else if (cnt_q == TMO_LAST) begin
                    state_d = S_ERROR;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            S_DECODE: begin
                op_d = opcode;
                case (opc_ext)
                    32'd0:         state_d = boundary;
                    32'd1, 32'd2:  state_d = S_MEM_ADDR;
                    32'd3, 32'd4:  state_d = S_EXEC_ALU;
                    32'd5:         state_d = S_JUMP;
                    32'd6:         state_d = zero_flag ? S_JUMP : boundary;
                    32'd7:         state_d = S_HALT;
                    default:       state_d = S_ERROR;
                endcase
            end
            S_EXEC_ALU: begin
                alu_en  = 1'b1;
                alu_op  = (op_ext == 32'd4);
                state_d = S_WRITEBACK;
            end
            S_MEM_ADDR: begin
                mem_req = 1'b1;
                mem_we  = (op_ext == 32'd2);
                cnt_d   = 8'd0;
                state_d = S_MEM_WAIT;
            end
            S_MEM_WAIT: begin
                mem_req = 1'b1;
                mem_we  = (op_ext == 32'd2);
                if (mem_ready) begin
                    state_d = (op_ext == 32'd2) ? boundary : S_WRITEBACK;
                end else if (cnt_q == TMO_LAST) begin
                    state_d = S_ERROR;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            S_WRITEBACK: state_d = boundary;
            S_JUMP: begin
                pc_load = 1'b1;
                state_d = boundary;
            end
            S_HALT: begin
                busy   = 1'b0;
                halted = 1'b1;
                if (!start) state_d = S_IDLE;
            end
            S_ERROR: begin
                busy  = 1'b0;
                error = 1'b1;
            end
            default: state_d = S_IDLE;
        endcase
    end

endmodule

// File: tb/tb_control_fsm.sv
// Scoreboard bench for control_fsm. The driver queues the expected state and strobes
// for every cycle, and a monitor on the falling edge pops each entry and compares it.
module tb_control_fsm;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic [15:0] IR = 16'd0;
    logic        mem_ready = 1'b0;
    logic        zero_flag = 1'b0;
    logic [5:0]  state;
    logic        mem_req, mem_we, ir_load, pc_inc, pc_load;
    logic        alu_en, alu_op, busy, halted, error;

    control_fsm #(.IR_WIDTH(16), .OPCODE_WIDTH(6), .STATE_WIDTH(6), .TIMEOUT(15)) dut (
        .clock(clock), .reset(reset), .start(start), .IR(IR),
        .mem_ready(mem_ready), .zero_flag(zero_flag), .state(state),
        .mem_req(mem_req), .mem_we(mem_we), .ir_load(ir_load), .pc_inc(pc_inc),
        .pc_load(pc_load), .alu_en(alu_en), .alu_op(alu_op), .busy(busy),
        .halted(halted), .error(error)
    );

    always #5 clock = ~clock;

    typedef struct {
        int         step;
        int         st;
        logic [9:0] outs;
    } exp_t;

    exp_t exp_q[$];
    int   n_cmp = 0;
    int   n_bad = 0;
    int   step_no = 0;
    int   cur_op = 0;

    // Bit order: mem_req mem_we ir_load pc_inc pc_load alu_en alu_op busy halted error
    function automatic logic [9:0] model(input int st, input int op, input logic mr);
        logic [9:0] o;
        o[9] = (st == 1 || st == 2 || st == 5 || st == 6);
        o[8] = (st == 5 || st == 6) && (op == 2);
        o[7] = (st == 2) && mr;
        o[6] = (st == 2) && mr;
        o[5] = (st == 8);
        o[4] = (st == 4);
        o[3] = (st == 4) && (op == 4);
        o[2] = !(st == 0 || st == 9 || st == 10);
        o[1] = (st == 9);
        o[0] = (st == 10);
        return o;
    endfunction

    // Drive one cycle: st is the state the DUT must be in during this cycle
    task automatic cyc(input logic s, input logic mr, input logic z, input int st);
        exp_t e;
        start     = s;
        mem_ready = mr;
        zero_flag = z;
        IR        = 16'(cur_op) << 10;
        e.step    = step_no;
        e.st      = st;
        e.outs    = model(st, cur_op, mr);
        exp_q.push_back(e);
        step_no++;
        @(posedge clock);
        #1;
    endtask

    task automatic fetch_decode(input int op, input logic s, input logic z);
        cur_op = op;
        cyc(s, 1'b0, 1'b0, 1);
        cyc(s, 1'b1, 1'b0, 2);
        cyc(s, 1'b0, z, 3);
    endtask

    always @(negedge clock) begin
        if (exp_q.size() > 0) begin
            exp_t e;
            logic [9:0] got;
            e   = exp_q.pop_front();
            got = {mem_req, mem_we, ir_load, pc_inc, pc_load, alu_en, alu_op, busy, halted, error};
            n_cmp++;
            if (state != 6'(e.st) || got !== e.outs) begin
                n_bad++;
                $display("FAIL step%0d state/strobes: got state=%0d outs=%b, want state=%0d outs=%b",
                         e.step, state, got, e.st, e.outs);
            end
        end
    end

    initial begin
        @(posedge clock);
        #1;
        start = 1'b1;
        cyc(1'b1, 1'b0, 1'b0, 0);
        reset = 1'b0;
        cyc(1'b1, 1'b0, 1'b0, 0);
        cyc(1'b1, 1'b0, 1'b0, 1);
        cyc(1'b1, 1'b0, 1'b0, 2);
        // Asynchronous reset in the middle of FETCH_WAIT
        reset = 1'b1;
        cyc(1'b1, 1'b0, 1'b0, 0);
        reset = 1'b0;
        cyc(1'b1, 1'b0, 1'b0, 0);

        // ADD then SUB: 1,2,3,4,7 and back to FETCH
        fetch_decode(3, 1'b1, 1'b0);
        cyc(1'b1, 1'b0, 1'b0, 4);
        cyc(1'b1, 1'b0, 1'b0, 7);
        fetch_decode(4, 1'b1, 1'b0);
        cyc(1'b1, 1'b0, 1'b0, 4);
        cyc(1'b1, 1'b0, 1'b0, 7);

        // STORE with three wait cycles in MEM_WAIT
        fetch_decode(2, 1'b1, 1'b0);
        cyc(1'b1, 1'b0, 1'b0, 5);
        cyc(1'b1, 1'b0, 1'b0, 6);
        cyc(1'b1, 1'b0, 1'b0, 6);
        cyc(1'b1, 1'b0, 1'b0, 6);
        cyc(1'b1, 1'b1, 1'b0, 6);

        // LOAD, JUMP, JUMPZ not taken, JUMPZ taken, NOP
        fetch_decode(1, 1'b1, 1'b0);
        cyc(1'b1, 1'b0, 1'b0, 5);
        cyc(1'b1, 1'b1, 1'b0, 6);
        cyc(1'b1, 1'b0, 1'b0, 7);
        fetch_decode(5, 1'b1, 1'b0);
        cyc(1'b1, 1'b0, 1'b0, 8);
        fetch_decode(6, 1'b1, 1'b0);
        fetch_decode(6, 1'b1, 1'b1);
        cyc(1'b1, 1'b0, 1'b0, 8);
        fetch_decode(0, 1'b1, 1'b0);

        // Ready arriving on the last allowed FETCH_WAIT cycle still completes the fetch
        cur_op = 0;
        cyc(1'b1, 1'b0, 1'b0, 1);
        for (int i = 0; i < 14; i++) cyc(1'b1, 1'b0, 1'b0, 2);
        cyc(1'b1, 1'b1, 1'b0, 2);
        cyc(1'b1, 1'b0, 1'b0, 3);

        // start dropped during ADD: finish, then IDLE until start returns
        cur_op = 3;
        cyc(1'b1, 1'b0, 1'b0, 1);
        cyc(1'b0, 1'b1, 1'b0, 2);
        cyc(1'b0, 1'b0, 1'b0, 3);
        cyc(1'b0, 1'b0, 1'b0, 4);
        cyc(1'b0, 1'b0, 1'b0, 7);
        cyc(1'b0, 1'b0, 1'b0, 0);
        cyc(1'b1, 1'b0, 1'b0, 0);

        // HALT holds while start=1, re-arms through IDLE
        fetch_decode(7, 1'b1, 1'b0);
        cyc(1'b1, 1'b0, 1'b0, 9);
        cyc(1'b0, 1'b0, 1'b0, 9);
        cyc(1'b1, 1'b0, 1'b0, 0);

        // Illegal opcode 12 -> sticky ERROR
        fetch_decode(12, 1'b1, 1'b0);
        cyc(1'b0, 1'b0, 1'b0, 10);
        cyc(1'b1, 1'b0, 1'b0, 10);
        cyc(1'b0, 1'b0, 1'b0, 10);
        reset = 1'b1;
        cyc(1'b1, 1'b0, 1'b0, 0);
        reset = 1'b0;
        cyc(1'b1, 1'b0, 1'b0, 0);

        // Fetch timeout: 15 cycles in FETCH_WAIT, then ERROR
        cur_op = 0;
        cyc(1'b1, 1'b0, 1'b0, 1);
        for (int i = 0; i < 15; i++) cyc(1'b1, 1'b0, 1'b0, 2);
        cyc(1'b0, 1'b0, 1'b0, 10);
        cyc(1'b1, 1'b0, 1'b0, 10);
        cyc(1'b0, 1'b1, 1'b0, 10);
        reset = 1'b1;
        cyc(1'b0, 1'b0, 1'b0, 0);

        for (int i = 0; i < 4 && exp_q.size() > 0; i++) @(negedge clock);
        n_cmp++;
        if (exp_q.size() != 0) begin
            n_bad++;
            $display("FAIL drain: got %0d entries left, want 0", exp_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/control_fsm.md
Name: control_fsm

Overview:
- Parametrised successor to the processor's fixed-opcode control state machine.
- Sequences fetch, decode and execute for the FPGA processor core, with opcode width and IR width set by parameters.
- Adds a memory ready/wait handshake with a timeout, a run/stop boundary on start, a halt state, an illegal-opcode error state, and decoded datapath control strobes.
- Sits between the instruction register/memory interface and the datapath (PC, ALU, register file).

Parameters:
IR_WIDTH, 16, instruction register width
OPCODE_WIDTH, 6, opcode field width; opcode = IR[IR_WIDTH-1 -: OPCODE_WIDTH]
STATE_WIDTH, 6, width of state output; must be >= 4
TIMEOUT, 15, maximum wait cycles for mem_ready (1..255)

Ports:
clock  input  1  system clock, rising edge
reset  input  1  asynchronous, active-high reset
start  input  1  run enable; sampled in IDLE, at instruction boundaries and in HALT
IR  input  IR_WIDTH  instruction register contents (external register, loaded on ir_load)
mem_ready  input  1  memory access complete
zero_flag  input  1  ALU zero flag, used by JUMPZ
state  output  STATE_WIDTH  current state encoding
mem_req  output  1  memory access request
mem_we  output  1  memory write (STORE)
ir_load  output  1  load IR from memory data
pc_inc  output  1  increment PC
pc_load  output  1  load PC from jump target
alu_en  output  1  ALU execute strobe
alu_op  output  1  0 = add, 1 = sub
busy  output  1  1 in every state except IDLE, HALT and ERROR
halted  output  1  1 in HALT
error  output  1  1 in ERROR

Behaviour:
- Reset is asynchronous, active-high. On assertion: state = IDLE (0), timeout counter = 0, latched opcode = 0. All outputs are 0. Reset mid-instruction aborts immediately.
- Flops: state register, 8-bit timeout counter, and op_q (opcode latched in DECODE).
- Outputs are combinational from state, plus mem_ready where noted below.
- State encodings: IDLE=0, FETCH=1, FETCH_WAIT=2, DECODE=3, EXEC_ALU=4, MEM_ADDR=5, MEM_WAIT=6, WRITEBACK=7, JUMP=8, HALT=9, ERROR=10.
- "Boundary" means: next state is FETCH if start=1, otherwise IDLE.
- IDLE: start=1 -> FETCH; otherwise stay in IDLE.
- FETCH: mem_req=1 -> FETCH_WAIT; timeout counter cleared.
- FETCH_WAIT:
  - mem_req=1.
  - If mem_ready=1: ir_load=1 and pc_inc=1 in the same cycle -> DECODE.
  - Else counter++. When counter == TIMEOUT-1 and mem_ready=0 -> ERROR.
  - mem_ready wins on the expiry cycle.
- DECODE: op_q <= opcode. Next state by opcode (zero-extended compare):
  - 0 NOP -> boundary
  - 1 LOAD, 2 STORE -> MEM_ADDR
  - 3 ADD, 4 SUB -> EXEC_ALU
  - 5 JUMP -> JUMP
  - 6 JUMPZ -> JUMP if zero_flag=1, else boundary
  - 7 HALT -> HALT
  - any other value -> ERROR
- EXEC_ALU: alu_en=1, alu_op=(op_q==4) -> WRITEBACK.
- MEM_ADDR: mem_req=1, mem_we=(op_q==2), counter cleared -> MEM_WAIT.
- MEM_WAIT:
  - mem_req and mem_we held.
  - mem_ready=1: LOAD -> WRITEBACK; STORE -> boundary.
  - Timeout rule identical to FETCH_WAIT.
- WRITEBACK -> boundary.
- JUMP: pc_load=1 -> boundary.
- HALT: halted=1. Stays while start=1; start=0 -> IDLE, so the host must drop start to re-arm.
- ERROR: error=1. Sticky until reset; start is ignored.
- Cycle counts with mem_ready=1 the cycle after each request:
  - NOP: 3 cycles
  - ADD/SUB: 5 cycles
  - LOAD: 6 cycles
  - STORE: 5 cycles
  - JUMP: 4 cycles
- Each additional wait cycle adds 1.
- start=0 mid-instruction has no effect until the next boundary.

Test Plan:
- Reset with start=1: assert reset mid-FETCH_WAIT -> state=0 asynchronously, all outputs 0. Release reset -> FETCH on the next edge.
- ADD (IR[15:10]=3), mem_ready=1 always -> state sequence 1,2,3,4,7,1. alu_en=1 with alu_op=0 in state 4. SUB (opcode 4) gives alu_op=1.
- STORE (opcode 2), mem_ready held low 3 cycles in MEM_WAIT -> mem_req=1 and mem_we=1 for all 4 cycles, then boundary.
- Timeout: mem_ready=0 in FETCH_WAIT -> ERROR after exactly 15 cycles, with error=1 and busy=0. start toggling does not leave ERROR; only reset clears it.
- Control flow:
  - JUMPZ with zero_flag=0 -> pc_load stays 0, returns to FETCH.
  - JUMPZ with zero_flag=1 -> JUMP (8) with pc_load=1.
  - Opcode 12 -> ERROR (10).
- Run/stop: start=0 during an ADD -> completes WRITEBACK, then IDLE. Opcode 7 -> HALT (9) with halted=1; drop start -> IDLE; raise start -> FETCH.
